// File: rtl/icache.sv
// Direct-mapped instruction cache: 2**INDEX_BITS lines of four 32-bit words.
// Hits return the word one cycle after the request is sampled. Misses fill
// the whole line with four sequential word reads, then return the word.
module icache #(
  parameter int INDEX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clr,
  input  logic        if_to_ic_enable,
  input  logic [31:0] if_to_ic_pc,
  output logic        ic_to_if_done,
  output logic [31:0] ic_to_if_inst,
  output logic        ic_to_mc_enable,
  output logic [31:0] ic_to_mc_pc,
  input  logic        mc_to_ic_done,
  input  logic [31:0] mc_to_ic_result
);

  localparam int LINES = 2 ** INDEX_BITS;
  localparam int TAG_W = 28 - INDEX_BITS;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_FILL = 1'b1;

  logic [0:0]            state_q;
  logic [31:2]           req_pc_q;
  logic [1:0]            fill_cnt_q;
  logic [31:0]           buf_q [3];
  logic                  done_q;
  logic [31:0]           inst_q;
  logic                  mc_en_q;
  logic [31:0]           mc_pc_q;
  logic [LINES-1:0]      valid_q;
  logic [TAG_W-1:0]      tag_q [LINES];

  logic [INDEX_BITS-1:0] rd_idx;
  logic [TAG_W-1:0]      rd_tag;
  logic [1:0]            rd_off;
  logic [INDEX_BITS-1:0] wr_idx;
  logic [TAG_W-1:0]      wr_tag;
  logic [31:0]           rd_words [4];
  logic [31:0]           line_words [4];
  logic                  hit;
  logic                  line_wr;
  logic [1:0]            cnt_inc;

  assign rd_off  = if_to_ic_pc[3:2];
  assign rd_idx  = if_to_ic_pc[INDEX_BITS+3:4];
  assign rd_tag  = if_to_ic_pc[31:INDEX_BITS+4];
  assign wr_idx  = req_pc_q[INDEX_BITS+3:4];
  assign wr_tag  = req_pc_q[31:INDEX_BITS+4];
  assign hit     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign cnt_inc = fill_cnt_q + 2'd1;

  // The last fill word comes straight from memory; it is never buffered.
  always_comb begin
    line_words[0] = buf_q[0];
    line_words[1] = buf_q[1];
    line_words[2] = buf_q[2];
    line_words[3] = mc_to_ic_result;
  end

  // Commit the line only when the fourth word lands and nothing overrides it.
  assign line_wr = !rst && !clr && rdy && (state_q == S_FILL) &&
                   mc_to_ic_done && (fill_cnt_q == 2'd3);

  // One storage array per word column, combinational read for same-cycle hit compare.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : gen_word
      logic [31:0] mem_q [LINES];

      // Column write at fill completion.
      always_ff @(posedge clk) begin
        if (line_wr) mem_q[wr_idx] <= line_words[gi];
      end

      assign rd_words[gi] = mem_q[rd_idx];
    end
  endgenerate

  // Tag array written together with the data so a line is never partially valid.
  always_ff @(posedge clk) begin
    if (line_wr) tag_q[wr_idx] <= wr_tag;
  end

  // Control FSM, valid bits and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      req_pc_q   <= '0;
      fill_cnt_q <= 2'd0;
      done_q     <= 1'b0;
      inst_q     <= '0;
      mc_en_q    <= 1'b0;
      mc_pc_q    <= '0;
      valid_q    <= '0;
    end else if (clr) begin
      // Abort: partial buffer is simply abandoned, arrays untouched.
      state_q    <= S_IDLE;
      fill_cnt_q <= 2'd0;
      done_q     <= 1'b0;
      mc_en_q    <= 1'b0;
    end else if (rdy) begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // The done cycle itself blocks acceptance of the still-held request.
          if (if_to_ic_enable && !done_q) begin
            if (hit) begin
              done_q <= 1'b1;
              inst_q <= rd_words[rd_off];
            end else begin
              req_pc_q   <= if_to_ic_pc[31:2];
              fill_cnt_q <= 2'd0;
              state_q    <= S_FILL;
              mc_en_q    <= 1'b1;
              // Low pc bits are masked to zero: memory requests are word aligned.
              mc_pc_q    <= {if_to_ic_pc[31:4], 2'b00, if_to_ic_pc[1:0] & 2'b00};
            end
          end
        end
        default: begin
          if (mc_to_ic_done) begin
            if (fill_cnt_q != 2'd3) begin
              buf_q[fill_cnt_q] <= mc_to_ic_result;
              fill_cnt_q        <= cnt_inc;
              mc_pc_q           <= {req_pc_q[31:4], cnt_inc, 2'b00};
            end else begin
              valid_q[wr_idx] <= 1'b1;
              mc_en_q         <= 1'b0;
              done_q          <= 1'b1;
              inst_q          <= line_words[req_pc_q[3:2]];
              fill_cnt_q      <= 2'd0;
              state_q         <= S_IDLE;
            end
          end
        end
      endcase
    end
  end

  assign ic_to_if_done   = done_q;
  assign ic_to_if_inst   = inst_q;
  assign ic_to_mc_enable = mc_en_q;
  assign ic_to_mc_pc     = mc_pc_q;

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: misses, hits, conflict eviction, flush and stall.
module tb_icache;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        clr;
  logic        if_to_ic_enable;
  logic [31:0] if_to_ic_pc;
  logic        ic_to_if_done;
  logic [31:0] ic_to_if_inst;
  logic        ic_to_mc_enable;
  logic [31:0] ic_to_mc_pc;
  logic        mc_to_ic_done;
  logic [31:0] mc_to_ic_result;

  int errors = 0;
  int checks = 0;

  icache #(.INDEX_BITS(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .rdy             (rdy),
    .clr             (clr),
    .if_to_ic_enable (if_to_ic_enable),
    .if_to_ic_pc     (if_to_ic_pc),
    .ic_to_if_done   (ic_to_if_done),
    .ic_to_if_inst   (ic_to_if_inst),
    .ic_to_mc_enable (ic_to_mc_enable),
    .ic_to_mc_pc     (ic_to_mc_pc),
    .mc_to_ic_done   (mc_to_ic_done),
    .mc_to_ic_result (mc_to_ic_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: 0x11..0x44 in the first line, address ^ 0xCAFE0000 elsewhere.
  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a < 32'h10) begin
      case (a[3:2])
        2'd0:    mem = 32'h0000_0011;
        2'd1:    mem = 32'h0000_0022;
        2'd2:    mem = 32'h0000_0033;
        default: mem = 32'h0000_0044;
      endcase
    end else begin
      mem = a ^ 32'hCAFE_0000;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Answer one memory read at addr after lat idle cycles; last marks the 4th word.
  task automatic serve(input logic [31:0] addr, input bit last,
                       input logic [31:0] exp_inst, input int lat);
    for (int i = 0; i < lat; i++) begin
      check("mc_pc_hold", ic_to_mc_pc, addr);
      tick();
    end
    check("mc_en_req", {31'd0, ic_to_mc_enable}, 32'd1);
    check("mc_pc_req", ic_to_mc_pc, addr);
    mc_to_ic_done   = 1'b1;
    mc_to_ic_result = mem(addr);
    tick();
    mc_to_ic_done   = 1'b0;
    if (!last) begin
      check("mc_pc_next", ic_to_mc_pc, addr + 32'd4);
      check("done_mid", {31'd0, ic_to_if_done}, 32'd0);
    end else begin
      check("mc_en_off", {31'd0, ic_to_mc_enable}, 32'd0);
      check("done_miss", {31'd0, ic_to_if_done}, 32'd1);
      check("inst_miss", ic_to_if_inst, exp_inst);
    end
  endtask

  // Present a request, expect a miss, serve four words and expect the result.
  task automatic fetch_miss(input logic [31:0] pc, input logic [31:0] exp_inst, input int lat);
    logic [31:0] base;
    base = {pc[31:4], 4'h0};
    if_to_ic_enable = 1'b1;
    if_to_ic_pc     = pc;
    tick();
    check("miss_done0", {31'd0, ic_to_if_done}, 32'd0);
    check("miss_base", ic_to_mc_pc, base);
    for (int w = 0; w < 4; w++)
      serve(base + 32'(4 * w), (w == 3), exp_inst, lat);
    if_to_ic_enable = 1'b0;
    tick();
    check("done_pulse", {31'd0, ic_to_if_done}, 32'd0);
    check("mc_idle", {31'd0, ic_to_mc_enable}, 32'd0);
    $display("txn miss pc=%h inst=%h", pc, exp_inst);
  endtask

  task automatic fetch_hit(input logic [31:0] pc, input logic [31:0] exp_inst);
    if_to_ic_enable = 1'b1;
    if_to_ic_pc     = pc;
    tick();
    check("hit_done", {31'd0, ic_to_if_done}, 32'd1);
    check("hit_inst", ic_to_if_inst, exp_inst);
    check("hit_no_mc", {31'd0, ic_to_mc_enable}, 32'd0);
    if_to_ic_enable = 1'b0;
    tick();
    check("hit_pulse", {31'd0, ic_to_if_done}, 32'd0);
    $display("txn hit  pc=%h inst=%h", pc, exp_inst);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; clr = 1'b0;
    if_to_ic_enable = 1'b0; if_to_ic_pc = '0;
    mc_to_ic_done = 1'b0; mc_to_ic_result = '0;
    tick();
    tick();
    check("rst_done", {31'd0, ic_to_if_done}, 32'd0);
    check("rst_inst", ic_to_if_inst, 32'd0);
    check("rst_mc_en", {31'd0, ic_to_mc_enable}, 32'd0);
    check("rst_mc_pc", ic_to_mc_pc, 32'd0);
    rst = 1'b0;
    tick();

    // Cold miss on line 0, then a hit on its second word.
    fetch_miss(32'h0000_0000, 32'h0000_0011, 1);
    fetch_hit(32'h0000_0004, 32'h0000_0022);

    // Offset 3: returned word is forwarded from the last memory read.
    fetch_miss(32'h0000_001C, 32'hCAFE_001C, 2);
    fetch_hit(32'h0000_0014, 32'hCAFE_0014);

    // Conflict on index 0: 0x100 evicts 0x0, which then misses again.
    fetch_miss(32'h0000_0100, 32'hCAFE_0100, 1);
    fetch_hit(32'h0000_0108, 32'hCAFE_0108);
    fetch_miss(32'h0000_0000, 32'h0000_0011, 1);

    // Flush after two words of a fill at 0x40, with a coincident done dropped.
    if_to_ic_enable = 1'b1;
    if_to_ic_pc     = 32'h0000_0040;
    tick();
    serve(32'h0000_0040, 1'b0, 32'd0, 1);
    serve(32'h0000_0044, 1'b0, 32'd0, 1);
    clr             = 1'b1;
    if_to_ic_enable = 1'b0;
    mc_to_ic_done   = 1'b1;
    mc_to_ic_result = mem(32'h0000_0048);
    tick();
    clr           = 1'b0;
    mc_to_ic_done = 1'b0;
    check("clr_mc_en", {31'd0, ic_to_mc_enable}, 32'd0);
    check("clr_done", {31'd0, ic_to_if_done}, 32'd0);
    tick();
    check("clr_done2", {31'd0, ic_to_if_done}, 32'd0);
    $display("txn flush pc=00000040");
    fetch_miss(32'h0000_0040, 32'hCAFE_0040, 1);
    fetch_hit(32'h0000_0000, 32'h0000_0011);

    // Stall for three cycles during a fill at 0x88 with done held high.
    if_to_ic_enable = 1'b1;
    if_to_ic_pc     = 32'h0000_0088;
    tick();
    serve(32'h0000_0080, 1'b0, 32'd0, 1);
    rdy             = 1'b0;
    mc_to_ic_done   = 1'b1;
    mc_to_ic_result = mem(32'h0000_0084);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_mc_pc", ic_to_mc_pc, 32'h0000_0084);
      check("stall_mc_en", {31'd0, ic_to_mc_enable}, 32'd1);
      check("stall_done", {31'd0, ic_to_if_done}, 32'd0);
    end
    rdy = 1'b1;
    tick();
    mc_to_ic_done = 1'b0;
    check("resume_pc", ic_to_mc_pc, 32'h0000_0088);
    serve(32'h0000_0088, 1'b0, 32'd0, 1);
    serve(32'h0000_008C, 1'b1, 32'hCAFE_0088, 1);
    if_to_ic_enable = 1'b0;
    tick();
    check("stall_pulse", {31'd0, ic_to_if_done}, 32'd0);
    $display("txn stall-miss pc=00000088 inst=cafe0088");

    // Back-to-back hits with enable held: done every other cycle.
    if_to_ic_enable = 1'b1;
    if_to_ic_pc     = 32'h0000_0000;
    tick();
    check("b2b_done0", {31'd0, ic_to_if_done}, 32'd1);
    check("b2b_inst0", ic_to_if_inst, 32'h0000_0011);
    if_to_ic_pc = 32'h0000_0004;
    tick();
    check("b2b_gap", {31'd0, ic_to_if_done}, 32'd0);
    tick();
    check("b2b_done1", {31'd0, ic_to_if_done}, 32'd1);
    check("b2b_inst1", ic_to_if_inst, 32'h0000_0022);
    if_to_ic_enable = 1'b0;
    tick();
    $display("txn back-to-back hits pc=00000000,00000004");

    // Reset clears valid bits: line 0 misses afterwards.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    fetch_miss(32'h0000_0008, 32'h0000_0033, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
